fsm_mod_counter: RTL and testbench

- Parametrised FSM event counter: the count register is the state, S0..S(MODULUS-1), and it advances on qualified din events.
- Adds up/down direction, enable, synchronous load and clear, wrap or saturate mode, a level or rising-edge event mode, a terminal-count pulse and a sticky overflow flag.
- Sits between input conditioning and control/display logic as the standard counting primitive.
- Defaults (WIDTH=2, MODULUS=4, level mode, wrap) give a mod-4 din counter.

---
 rtl/fsm_counter_pkg.sv | 26 ++
 rtl/fsm_evt_detect.sv | 33 +++
 rtl/fsm_mod_counter.sv | 111 +++++++++++
 tb/tb_fsm_mod_counter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_counter_pkg.sv
// Shared constants, action encoding and load clamping for the fsm_mod_counter family.
package fsm_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;
  localparam int MODE_WRAP  = 0;
  localparam int MODE_SAT   = 1;

  // Winning action for a clock edge, in priority order clear > load > step.
  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_CLEAR = 2'd1,
    ACT_LOAD  = 2'd2,
    ACT_STEP  = 2'd3
  } act_e;

  // Out-of-range load values land on the terminal state rather than an illegal one.
  function automatic int unsigned clamp_load(input int unsigned val,
                                             input int unsigned modulus);
    return (val < modulus) ? val : (modulus - 1);
  endfunction

endpackage

// File: rtl/fsm_evt_detect.sv
// Event qualifier for fsm_mod_counter: level pass-through or 0->1 edge detection on din.
module fsm_evt_detect
  import fsm_counter_pkg::*;
#(
  parameter int EDGE_MODE = MODE_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic evt
);

  logic din_d;
  logic armed;

  always_ff @(posedge clk) begin
    if (reset) begin
      din_d <= 1'b0;
      armed <= 1'b0;
    end else begin
      din_d <= din;
      armed <= 1'b1;
    end
  end

  // A din already high when reset releases is a level, not a fresh edge, so the
  // first post-reset edge only primes din_d and never produces an edge event.
  always_comb begin
    if (EDGE_MODE == MODE_EDGE) evt = din & ~din_d & armed;
    else                        evt = din;
  end

endmodule

// File: rtl/fsm_mod_counter.sv
// Modulus-N event counter whose count register is the FSM state; supports
// up/down, load, clear, wrap or saturate, terminal-count pulse and sticky overflow.
module fsm_mod_counter
  import fsm_counter_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MODULUS   = 4,
  parameter int SATURATE  = MODE_WRAP,
  parameter int EDGE_MODE = MODE_LEVEL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("fsm_mod_counter: MODULUS %0d outside 2..2**WIDTH (WIDTH=%0d)", MODULUS, WIDTH);
  end

  // Arithmetic is one bit wider than the count so MODULUS == 2**WIDTH cannot overflow.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);

  logic             evt;
  act_e             act;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   cnt_ext, nxt_ext;
  logic             at_bound;

  fsm_evt_detect #(
    .EDGE_MODE(EDGE_MODE)
  ) u_evt (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .evt  (evt)
  );

  always_comb begin
    act = ACT_HOLD;
    if (clear)          act = ACT_CLEAR;
    else if (load)      act = ACT_LOAD;
    else if (en && evt) act = ACT_STEP;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    cnt_ext  = {1'b0, count_q};
    nxt_ext  = cnt_ext;
    at_bound = 1'b0;
    tc_d     = 1'b0;
    ovf_d    = ovf_q;
    count_d  = count_q;
    case (act)
      ACT_CLEAR: begin
        nxt_ext = '0;
        ovf_d   = 1'b0;
      end
      ACT_LOAD: begin
        nxt_ext = (WIDTH+1)'(clamp_load(32'(load_val), MODULUS));
      end
      ACT_STEP: begin
        if (up_dn == DIR_UP) begin
          at_bound = (cnt_ext == LAST);
          if (!at_bound)                    nxt_ext = cnt_ext + 1'b1;
          else if (SATURATE == MODE_WRAP)   nxt_ext = '0;
        end else begin
          at_bound = (cnt_ext == '0);
          if (!at_bound)                    nxt_ext = cnt_ext - 1'b1;
          else if (SATURATE == MODE_WRAP)   nxt_ext = LAST;
        end
        if (at_bound) begin
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
      default: nxt_ext = cnt_ext;
    endcase
    count_d = nxt_ext[WIDTH-1:0];
  end

  // Outputs come straight from the registers.
  always_comb begin
    count = count_q;
    tc    = tc_q;
    ovf   = ovf_q;
  end

endmodule

// File: tb/tb_fsm_mod_counter.sv
// Self-checking bench for fsm_mod_counter across four parameterisations sharing one stimulus bus.
module tb_fsm_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, din, up_dn, load, clear;
  logic [3:0] load_val;

  logic [1:0] count0; logic tc0, ovf0;
  logic [3:0] count1; logic tc1, ovf1;
  logic [3:0] count2; logic tc2, ovf2;
  logic [2:0] count3; logic tc3, ovf3;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] exp_q[$];

  typedef struct {
    int rst, clr, ld, lv, en, din, up, c, t, o;
  } vec_t;

  always #5 clk = ~clk;

  // sel 0: defaults (mod-4, wrap, level)
  fsm_mod_counter u_def (
    .clk(clk), .reset(reset), .en(en), .din(din), .up_dn(up_dn), .load(load),
    .load_val(load_val[1:0]), .clear(clear), .count(count0), .tc(tc0), .ovf(ovf0));

  // sel 1: mod-10 saturating, level
  fsm_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .EDGE_MODE(0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .din(din), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .count(count1), .tc(tc1), .ovf(ovf1));

  // sel 2: mod-10 wrap, edge events
  fsm_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .EDGE_MODE(1)) u_edge (
    .clk(clk), .reset(reset), .en(en), .din(din), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .count(count2), .tc(tc2), .ovf(ovf2));

  // sel 3: mod-8 wrap, level
  fsm_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0), .EDGE_MODE(0)) u_w3 (
    .clk(clk), .reset(reset), .en(en), .din(din), .up_dn(up_dn), .load(load),
    .load_val(load_val[2:0]), .clear(clear), .count(count3), .tc(tc3), .ovf(ovf3));

  function automatic logic [5:0] obs(input int sel);
    case (sel)
      0:       return {2'b00, count0, tc0, ovf0};
      1:       return {count1, tc1, ovf1};
      2:       return {count2, tc2, ovf2};
      default: return {1'b0, count3, tc3, ovf3};
    endcase
  endfunction

  function automatic logic [5:0] mk(input vec_t v);
    return {4'(v.c), 1'(v.t), 1'(v.o)};
  endfunction

  task automatic drive(input vec_t v);
    reset    = 1'(v.rst);
    clear    = 1'(v.clr);
    load     = 1'(v.ld);
    load_val = 4'(v.lv);
    en       = 1'(v.en);
    din      = 1'(v.din);
    up_dn    = 1'(v.up);
  endtask

  task automatic apply_reset();
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    en = 1'b0; din = 1'b0; up_dn = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got, exp;
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(6'b0);
      got = obs(s);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset[sel%0d]: got {count,tc,ovf}=%b expected %b", s, got, exp);
      end
    end
  endtask

  task automatic test_wrap_default();
    vec_t v[6] = '{
      '{0,0,0,0,1,1,1, 1,0,0}, '{0,0,0,0,1,1,1, 2,0,0}, '{0,0,0,0,1,1,1, 3,0,0},
      '{0,0,0,0,1,1,1, 0,1,1}, '{0,0,0,0,1,1,1, 1,0,1}, '{0,0,0,0,1,1,1, 2,0,1}};
    logic [5:0] got, exp;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(0);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL wrap_default[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_saturate();
    vec_t v[7] = '{
      '{0,0,1,2,0,0,0, 2,0,0},
      '{0,0,0,0,1,1,0, 1,0,0}, '{0,0,0,0,1,1,0, 0,0,0},
      '{0,0,0,0,1,1,0, 0,1,1}, '{0,0,0,0,1,1,0, 0,1,1},
      '{0,0,0,0,1,0,0, 0,0,1},
      '{0,1,0,0,1,0,0, 0,0,0}};
    logic [5:0] got, exp;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(1);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL saturate[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_edge();
    vec_t v[13] = '{
      '{0,0,0,0,1,0,1, 0,0,0}, '{0,0,0,0,1,1,1, 1,0,0}, '{0,0,0,0,1,1,1, 1,0,0},
      '{0,0,0,0,1,1,1, 1,0,0}, '{0,0,0,0,1,0,1, 1,0,0}, '{0,0,0,0,1,1,1, 2,0,0},
      '{0,0,0,0,1,0,1, 2,0,0}, '{0,0,0,0,1,1,1, 3,0,0},
      '{0,0,0,0,1,0,1, 3,0,0}, '{0,0,0,0,0,1,1, 3,0,0}, '{0,0,0,0,1,1,1, 3,0,0},
      '{0,0,0,0,1,0,1, 3,0,0}, '{0,0,0,0,1,1,1, 4,0,0}};
    logic [5:0] got, exp;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(2);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL edge[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_load();
    vec_t v[7] = '{
      '{0,0,1,13,0,0,1, 9,0,0},
      '{0,0,1, 5,1,1,1, 5,0,0},
      '{0,0,0, 0,1,1,1, 6,0,0},
      '{0,1,1, 4,0,0,1, 0,0,0},
      '{0,0,1, 9,0,0,1, 9,0,0},
      '{0,0,0, 0,1,1,1, 9,1,1},
      '{0,0,1, 3,0,0,1, 3,0,1}};
    logic [5:0] got, exp;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(1);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL load[%0d]: got %b expected %b", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v[12] = '{
      '{0,0,0,0,1,0,1, 0,0,0}, '{0,0,0,0,1,1,1, 1,0,0}, '{0,0,0,0,1,0,1, 1,0,0},
      '{0,0,0,0,1,1,1, 2,0,0}, '{0,0,0,0,1,1,1, 2,0,0},
      '{1,0,0,0,1,1,1, 0,0,0}, '{1,0,0,0,1,1,1, 0,0,0},
      '{0,0,0,0,1,1,1, 0,0,0}, '{0,0,0,0,1,1,1, 0,0,0},
      '{0,0,0,0,1,0,1, 0,0,0}, '{0,0,0,0,1,1,1, 1,0,0}, '{0,0,0,0,1,1,1, 1,0,0}};
    logic [5:0] got, exp;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(2);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL reset_mid[%0d]: got %b expected %b", i, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap3();
    vec_t v[4] = '{
      '{0,0,1,7,0,0,1, 7,0,0},
      '{0,0,0,0,1,1,1, 0,1,1},
      '{0,0,0,0,1,1,0, 7,1,1},
      '{0,0,0,0,1,1,0, 6,0,1}};
    logic [5:0] got, exp;
    int c, nc, t, d, u;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      exp_q.push_back(mk(v[i]));
      @(posedge clk); #1;
      got = obs(3);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL wrap3[%0d]: got %b expected %b", i, got, exp);
      end
    end
    c = 6;
    for (int i = 0; i < 24; i++) begin
      d = $urandom_range(0, 1);
      u = $urandom_range(0, 1);
      din = 1'(d); up_dn = 1'(u); en = 1'b1; load = 1'b0; clear = 1'b0;
      t = 0; nc = c;
      if (d == 1) begin
        if (u == 1) begin nc = (c == 7) ? 0 : c + 1; t = (c == 7) ? 1 : 0; end
        else        begin nc = (c == 0) ? 7 : c - 1; t = (c == 0) ? 1 : 0; end
      end
      exp_q.push_back({4'(nc), 1'(t), 1'b1});
      @(posedge clk); #1;
      got = obs(3);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp || $isunknown(got)) begin
        n_errors++;
        $display("FAIL wrap3_rand[%0d]: got %b expected %b", i, got, exp);
      end
      c = nc;
    end
  endtask

  initial begin
    test_reset();
    test_wrap_default();
    test_saturate();
    test_edge();
    test_load();
    test_reset_mid();
    test_wrap3();
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
